// File: rtl/hub_port_pkg.sv
// Shared types and helpers for the hub serial port: FSM encodings, clog2 and
// frame-length arithmetic.
package hub_port_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START_CHK,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Ceiling log2; clog2(1) is 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    function automatic int frame_bits(input int data_w, input int parity_en);
        return 1 + data_w + parity_en + 1;
    endfunction

    localparam int FRAME_BITS = frame_bits(8, 1);

endpackage

// File: rtl/hub_port_fifo.sv
// Synchronous FIFO buffering words for the transmit framer; head word is
// presented combinationally on rdata.
module hub_port_fifo
    import hub_port_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/hub_port_gen.sv
// Full-duplex asynchronous serial port: FIFO-buffered framer on tx and a
// mid-bit sampling deframer with glitch rejection on rx.
module hub_port_gen
    import hub_port_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tr_start,
    input  logic [DATA_W-1:0] din,
    output logic              tr_free,
    output logic              tx_busy,
    output logic              tx,
    input  logic              rx,
    output logic              rec_complete,
    output logic [DATA_W-1:0] dout,
    output logic              parity_err,
    output logic              frame_err
);

    localparam int DIV_W = clog2(CLKS_PER_BIT);
    localparam int BIT_W = clog2(DATA_W + 1);
    localparam int CNT_W = clog2(FIFO_DEPTH) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;
    logic [CNT_W-1:0]  fifo_count;

    hub_port_fifo #(
        .WIDTH(DATA_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (tr_start),
        .wdata(din),
        .pop  (fifo_pop),
        .rdata(fifo_head),
        .full (fifo_full),
        .empty(fifo_empty),
        .count(fifo_count)
    );

    assign tr_free = !fifo_full;

    tx_state_t         tx_state;
    tx_state_t         tx_state_next;
    logic [DIV_W-1:0]  tx_div;
    logic [BIT_W-1:0]  tx_bit_cnt;
    logic [DATA_W-1:0] tx_shreg;
    logic              tx_par;
    logic              tx_bit_end;
    logic              tx_line;

    assign tx_bit_end = (tx_div == DIV_LAST);
    assign tx_busy    = (tx_state != TX_IDLE) || (fifo_count != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= TX_IDLE;
        end else begin
            tx_state <= tx_state_next;
        end
    end

    // Popping at the end of STOP chains queued words with no idle gap.
    always_comb begin
        tx_state_next = tx_state;
        fifo_pop      = 1'b0;
        tx_line       = 1'b1;
        case (tx_state)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop      = 1'b1;
                    tx_state_next = TX_START;
                end
            end
            TX_START: begin
                tx_line = 1'b0;
                if (tx_bit_end) begin
                    tx_state_next = TX_DATA;
                end
            end
            TX_DATA: begin
                tx_line = tx_shreg[0];
                if (tx_bit_end && tx_bit_cnt == BIT_LAST) begin
                    if (PARITY_EN != 0) begin
                        tx_state_next = TX_PARITY;
                    end else begin
                        tx_state_next = TX_STOP;
                    end
                end
            end
            TX_PARITY: begin
                tx_line = tx_par;
                if (tx_bit_end) begin
                    tx_state_next = TX_STOP;
                end
            end
            TX_STOP: begin
                if (tx_bit_end) begin
                    if (!fifo_empty) begin
                        fifo_pop      = 1'b1;
                        tx_state_next = TX_START;
                    end else begin
                        tx_state_next = TX_IDLE;
                    end
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    // The line is registered, so it trails the state by one uniform cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx         <= 1'b1;
            tx_div     <= '0;
            tx_bit_cnt <= '0;
            tx_shreg   <= '0;
            tx_par     <= 1'b0;
        end else begin
            tx <= tx_line;
            if (fifo_pop) begin
                tx_shreg   <= fifo_head;
                tx_par     <= ^fifo_head;
                tx_div     <= '0;
                tx_bit_cnt <= '0;
            end else if (tx_state != TX_IDLE) begin
                if (tx_bit_end) begin
                    tx_div <= '0;
                    if (tx_state == TX_DATA) begin
                        tx_shreg   <= tx_shreg >> 1;
                        tx_bit_cnt <= tx_bit_cnt + BIT_W'(1);
                    end
                end else begin
                    tx_div <= tx_div + DIV_W'(1);
                end
            end
        end
    end

    rx_state_t         rx_state;
    rx_state_t         rx_state_next;
    logic              rx_s1;
    logic              rx_s2;
    logic              rx_prev;
    logic [DIV_W-1:0]  rx_div;
    logic [BIT_W-1:0]  rx_bit_cnt;
    logic [DATA_W-1:0] rx_shreg;
    logic [DATA_W-1:0] rx_shift_next;
    logic              rx_par;
    logic              rx_bit_end;
    logic              rx_done;

    assign rx_bit_end = (rx_div == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state <= RX_IDLE;
        end else begin
            rx_state <= rx_state_next;
        end
    end

    always_comb begin
        rx_state_next = rx_state;
        rx_done       = 1'b0;
        rx_shift_next = rx_shreg >> 1;
        rx_shift_next[DATA_W-1] = rx_s2;
        case (rx_state)
            RX_IDLE: begin
                if (rx_prev && !rx_s2) begin
                    rx_state_next = RX_START_CHK;
                end
            end
            RX_START_CHK: begin
                if (rx_div == DIV_HALF) begin
                    rx_state_next = rx_s2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_bit_end && rx_bit_cnt == BIT_LAST) begin
                    if (PARITY_EN != 0) begin
                        rx_state_next = RX_PARITY;
                    end else begin
                        rx_state_next = RX_STOP;
                    end
                end
            end
            RX_PARITY: begin
                if (rx_bit_end) begin
                    rx_state_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_bit_end) begin
                    rx_done       = 1'b1;
                    rx_state_next = RX_IDLE;
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    // After the half-bit start check, the divider restarts so each later
    // sample lands a whole bit period after the previous midpoint.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1        <= 1'b1;
            rx_s2        <= 1'b1;
            rx_prev      <= 1'b1;
            rx_div       <= '0;
            rx_bit_cnt   <= '0;
            rx_shreg     <= '0;
            rx_par       <= 1'b0;
            rec_complete <= 1'b0;
            dout         <= '0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            rx_s1        <= rx;
            rx_s2        <= rx_s1;
            rx_prev      <= rx_s2;
            rec_complete <= rx_done;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    rx_div     <= '0;
                    rx_bit_cnt <= '0;
                end
                RX_START_CHK: begin
                    if (rx_div == DIV_HALF) begin
                        rx_div <= '0;
                    end else begin
                        rx_div <= rx_div + DIV_W'(1);
                    end
                end
                default: begin
                    if (rx_bit_end) begin
                        rx_div <= '0;
                        if (rx_state == RX_DATA) begin
                            rx_shreg   <= rx_shift_next;
                            rx_bit_cnt <= rx_bit_cnt + BIT_W'(1);
                        end
                        if (rx_state == RX_PARITY) begin
                            rx_par <= rx_s2;
                        end
                    end else begin
                        rx_div <= rx_div + DIV_W'(1);
                    end
                end
            endcase
            if (rx_done) begin
                dout       <= rx_shreg;
                parity_err <= (PARITY_EN != 0) && (rx_par != ^rx_shreg);
                frame_err  <= !rx_s2;
            end
        end
    end

endmodule

// File: tb/tb_hub_port_gen.sv
// Testbench for hub_port_gen: a cross-connected 8-bit pair plus a 12-bit
// no-parity loopback, with bench-driven rx frames and scoreboards.
module tb_hub_port_gen;

    localparam int CPB = 4;

    logic clk;
    logic reset;
    logic link_mode;
    logic bench_rx;

    logic       a_tr_start, a_tr_free, a_tx_busy, a_tx, a_rx, a_rec, a_pe, a_fe;
    logic [7:0] a_din, a_dout;
    logic       b_tr_start, b_tr_free, b_tx_busy, b_tx, b_rec, b_pe, b_fe;
    logic [7:0] b_din, b_dout;
    logic        c_tr_start, c_tr_free, c_tx_busy, c_tx, c_rec, c_pe, c_fe;
    logic [11:0] c_din, c_dout;

    int compared = 0;
    int failed   = 0;
    int cyc      = 0;

    assign a_rx = link_mode ? b_tx : bench_rx;

    hub_port_gen #(.DATA_W(8), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .PARITY_EN(1)) dut_a (
        .clk(clk), .reset(reset), .tr_start(a_tr_start), .din(a_din),
        .tr_free(a_tr_free), .tx_busy(a_tx_busy), .tx(a_tx), .rx(a_rx),
        .rec_complete(a_rec), .dout(a_dout), .parity_err(a_pe), .frame_err(a_fe)
    );

    hub_port_gen #(.DATA_W(8), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .PARITY_EN(1)) dut_b (
        .clk(clk), .reset(reset), .tr_start(b_tr_start), .din(b_din),
        .tr_free(b_tr_free), .tx_busy(b_tx_busy), .tx(b_tx), .rx(a_tx),
        .rec_complete(b_rec), .dout(b_dout), .parity_err(b_pe), .frame_err(b_fe)
    );

    hub_port_gen #(.DATA_W(12), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .PARITY_EN(0)) dut_c (
        .clk(clk), .reset(reset), .tr_start(c_tr_start), .din(c_din),
        .tr_free(c_tr_free), .tx_busy(c_tx_busy), .tx(c_tx), .rx(c_tx),
        .rec_complete(c_rec), .dout(c_dout), .parity_err(c_pe), .frame_err(c_fe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] data;
        logic        pe;
        logic        fe;
        int          at;
    } rx_evt_t;

    rx_evt_t a_q[$], b_q[$], c_q[$];
    rx_evt_t ev_a, ev_b, ev_c;

    always @(negedge clk) begin
        if (a_rec) begin
            ev_a.data = {8'h00, a_dout}; ev_a.pe = a_pe; ev_a.fe = a_fe; ev_a.at = cyc;
            a_q.push_back(ev_a);
        end
    end
    always @(negedge clk) begin
        if (b_rec) begin
            ev_b.data = {8'h00, b_dout}; ev_b.pe = b_pe; ev_b.fe = b_fe; ev_b.at = cyc;
            b_q.push_back(ev_b);
        end
    end
    always @(negedge clk) begin
        if (c_rec) begin
            ev_c.data = {4'h0, c_dout}; ev_c.pe = c_pe; ev_c.fe = c_fe; ev_c.at = cyc;
            c_q.push_back(ev_c);
        end
    end

    typedef struct {
        logic       start;
        logic [7:0] din;
        logic       exp_free;
        logic       exp_busy;
    } tx_vec_t;

    typedef struct {
        logic [7:0] word;
        logic       bad_par;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_pe;
        logic       exp_fe;
    } rx_vec_t;

    tx_vec_t tx_vecs[7];
    rx_vec_t rx_vecs[3];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    // Expected idle-high wire waveform, one entry per clock, from the frame rules.
    function automatic logic [63:0] build_wave(input logic [15:0] word, input int dw, input int pen);
        logic [63:0] w;
        logic        b;
        logic        par;
        int          pos;
        w   = '1;
        pos = 0;
        par = 1'b0;
        for (int k = 0; k < dw; k++) par ^= word[k];
        for (int k = 0; k < dw + 2 + pen; k++) begin
            if (k == 0) b = 1'b0;
            else if (k <= dw) b = word[k-1];
            else if (pen != 0 && k == dw + 1) b = par;
            else b = 1'b1;
            for (int c = 0; c < CPB; c++) begin
                w[pos] = b;
                pos++;
            end
        end
        return w;
    endfunction

    function automatic int qsize(input int which);
        case (which)
            0: return a_q.size();
            1: return b_q.size();
            default: return c_q.size();
        endcase
    endfunction

    task automatic wait_for(input int which, input int need, input int budget, input string name);
        int n;
        n = 0;
        while (qsize(which) < need && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (qsize(which) < need) checkOutput({name, "_timeout"}, 64'(qsize(which)), 64'(need));
    endtask

    task automatic check_rx(input int which, input logic [15:0] exp_data, input logic exp_pe,
                            input logic exp_fe, input int budget, input string name, output int at);
        rx_evt_t e;
        at = -1;
        wait_for(which, 1, budget, name);
        if (qsize(which) > 0) begin
            case (which)
                0: e = a_q.pop_front();
                1: e = b_q.pop_front();
                default: e = c_q.pop_front();
            endcase
            at = e.at;
            checkOutput({name, "_dout"}, 64'(e.data), 64'(exp_data));
            checkOutput({name, "_parity_err"}, 64'(e.pe), 64'(exp_pe));
            checkOutput({name, "_frame_err"}, 64'(e.fe), 64'(exp_fe));
        end
    endtask

    task automatic drive_rx_frame(input logic [7:0] word, input logic bad_par, input logic stop);
        logic [10:0] bits;
        bits = {stop, (^word) ^ bad_par, word, 1'b0};
        for (int k = 0; k < 11; k++) begin
            bench_rx = bits[k];
            repeat (CPB) @(negedge clk);
        end
        bench_rx = 1'b1;
    endtask

    task automatic applyStimulus(input tx_vec_t v, input int idx);
        a_tr_start = v.start;
        a_din      = v.din;
        @(negedge clk);
        checkOutput($sformatf("fifo_vec%0d_tr_free", idx), 64'(a_tr_free), 64'(v.exp_free));
        checkOutput($sformatf("fifo_vec%0d_tx_busy", idx), 64'(a_tx_busy), 64'(v.exp_busy));
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] cap;
        logic [7:0]  w8;
        logic        bp, st;
        logic [7:0]  exp_ab[$], exp_ba[$];
        rx_vec_t     rnd_q[$];
        rx_vec_t     rv;
        int          at, prev_at, lows;

        tx_vecs[0] = '{1'b1, 8'h01, 1'b1, 1'b1};
        tx_vecs[1] = '{1'b1, 8'h02, 1'b1, 1'b1};
        tx_vecs[2] = '{1'b1, 8'h03, 1'b1, 1'b1};
        tx_vecs[3] = '{1'b1, 8'h04, 1'b1, 1'b1};
        tx_vecs[4] = '{1'b1, 8'h05, 1'b0, 1'b1};
        tx_vecs[5] = '{1'b1, 8'h06, 1'b0, 1'b1};
        tx_vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b1};
        rx_vecs[0] = '{8'h47, 1'b1, 1'b1, 8'h47, 1'b1, 1'b0};
        rx_vecs[1] = '{8'h47, 1'b0, 1'b0, 8'h47, 1'b0, 1'b1};
        rx_vecs[2] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};

        reset = 1'b1; link_mode = 1'b1; bench_rx = 1'b1;
        a_tr_start = 0; a_din = '0; b_tr_start = 0; b_din = '0; c_tr_start = 0; c_din = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        $display("[TB] reset values");
        checkOutput("rst_tx", 64'(a_tx), 64'd1);
        checkOutput("rst_tr_free", 64'(a_tr_free), 64'd1);
        checkOutput("rst_tx_busy", 64'(a_tx_busy), 64'd0);
        checkOutput("rst_rec_complete", 64'(a_rec), 64'd0);
        checkOutput("rst_dout", 64'(a_dout), 64'd0);
        checkOutput("rst_parity_err", 64'(a_pe), 64'd0);
        checkOutput("rst_frame_err", 64'(a_fe), 64'd0);

        $display("[TB] overlapping A->B 0x47 and B->A 0x81");
        a_tr_start = 1'b1; a_din = 8'h47;
        @(negedge clk);
        a_tr_start = 1'b0;
        @(negedge clk);
        checkOutput("a_tx_latency_high", 64'(a_tx), 64'd1);
        cap = '1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            cap[i] = a_tx;
            if (i == 8) begin b_tr_start = 1'b1; b_din = 8'h81; end
            else b_tr_start = 1'b0;
        end
        checkOutput("a_wire_0x47", cap, build_wave(16'h0047, 8, 1));
        check_rx(1, 16'h0047, 1'b0, 1'b0, 200, "b_rx_0x47", at);
        check_rx(0, 16'h0081, 1'b0, 1'b0, 200, "a_rx_0x81", at);
        repeat (20) @(negedge clk);

        $display("[TB] five back-to-back pushes");
        a_q.delete(); b_q.delete();
        for (int i = 0; i < 7; i++) applyStimulus(tx_vecs[i], i);
        prev_at = -1;
        for (int i = 1; i <= 5; i++) begin
            check_rx(1, 16'(i), 1'b0, 1'b0, 300, $sformatf("burst_rx%0d", i), at);
            if (i > 1 && prev_at >= 0 && at >= 0)
                checkOutput($sformatf("burst_gap%0d", i), 64'(at - prev_at), 64'(11 * CPB));
            prev_at = at;
        end
        repeat (100) @(negedge clk);
        checkOutput("burst_sixth_dropped", 64'(b_q.size()), 64'd0);
        checkOutput("burst_idle_busy", 64'(a_tx_busy), 64'd0);

        $display("[TB] bench-driven rx vectors");
        link_mode = 1'b0;
        a_q.delete();
        for (int i = 0; i < 3; i++) begin
            drive_rx_frame(rx_vecs[i].word, rx_vecs[i].bad_par, rx_vecs[i].stop);
            check_rx(0, 16'(rx_vecs[i].exp_data), rx_vecs[i].exp_pe, rx_vecs[i].exp_fe, 40,
                     $sformatf("rx_vec%0d", i), at);
            repeat (8) @(negedge clk);
        end

        $display("[TB] one-cycle glitch then 0xA5");
        bench_rx = 1'b0;
        @(negedge clk);
        bench_rx = 1'b1;
        repeat (3) @(negedge clk);
        drive_rx_frame(8'hA5, 1'b0, 1'b1);
        check_rx(0, 16'h00A5, 1'b0, 1'b0, 40, "glitch_then_a5", at);
        repeat (10) @(negedge clk);
        checkOutput("glitch_no_extra", 64'(a_q.size()), 64'd0);

        $display("[TB] random rx frames");
        for (int i = 0; i < 16; i++) begin
            w8 = 8'($urandom);
            bp = ($urandom_range(0, 3) == 0);
            st = ($urandom_range(0, 3) != 0);
            rv = '{w8, bp, st, w8, bp, ~st};
            rnd_q.push_back(rv);
            drive_rx_frame(w8, bp, st);
            repeat ($urandom_range(2, 8)) @(negedge clk);
        end
        for (int i = 0; i < 16; i++) begin
            rv = rnd_q.pop_front();
            check_rx(0, 16'(rv.exp_data), rv.exp_pe, rv.exp_fe, 60, $sformatf("rnd_rx%0d", i), at);
        end

        $display("[TB] random bidirectional traffic");
        link_mode = 1'b1;
        a_q.delete(); b_q.delete();
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 40)) @(negedge clk);
            if (a_tr_free) begin
                a_tr_start = 1'b1; a_din = 8'($urandom); exp_ab.push_back(a_din);
            end
            if (b_tr_free) begin
                b_tr_start = 1'b1; b_din = 8'($urandom); exp_ba.push_back(b_din);
            end
            @(negedge clk);
            a_tr_start = 1'b0; b_tr_start = 1'b0;
        end
        while (exp_ab.size() > 0) begin
            w8 = exp_ab.pop_front();
            check_rx(1, 16'(w8), 1'b0, 1'b0, 600, "rnd_ab", at);
        end
        while (exp_ba.size() > 0) begin
            w8 = exp_ba.pop_front();
            check_rx(0, 16'(w8), 1'b0, 1'b0, 600, "rnd_ba", at);
        end
        repeat (20) @(negedge clk);

        $display("[TB] reset mid-frame");
        a_q.delete(); b_q.delete();
        a_tr_start = 1'b1; a_din = 8'h11; @(negedge clk);
        a_din = 8'h22; @(negedge clk);
        a_din = 8'h33; @(negedge clk);
        a_tr_start = 1'b0;
        repeat (15) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("midrst_tx", 64'(a_tx), 64'd1);
        checkOutput("midrst_tr_free", 64'(a_tr_free), 64'd1);
        checkOutput("midrst_tx_busy", 64'(a_tx_busy), 64'd0);
        lows = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (a_tx == 1'b0) lows++;
        end
        checkOutput("midrst_no_frames", 64'(lows), 64'd0);
        checkOutput("midrst_no_rx", 64'(b_q.size()), 64'd0);

        $display("[TB] 12-bit no-parity loopback");
        c_q.delete();
        c_tr_start = 1'b1; c_din = 12'hABC;
        @(negedge clk);
        c_tr_start = 1'b0;
        @(negedge clk);
        checkOutput("c_tx_latency_high", 64'(c_tx), 64'd1);
        cap = '1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            cap[i] = c_tx;
        end
        checkOutput("c_wire_0xabc", cap, build_wave(16'h0ABC, 12, 0));
        check_rx(2, 16'h0ABC, 1'b0, 1'b0, 100, "c_rx_0xabc", at);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule

// File: doc/hub_port_gen.md
Name: hub_port_gen

Overview:
- Parametrised successor to the hub's serial Port: full-duplex asynchronous serial link endpoint, one per hub port.
- Transmit side: a buffered TX FIFO feeds a framer that emits start / DATA_W data bits / optional even parity / stop on `tx`.
- Receive side: deserialises `rx` with mid-bit sampling, glitch rejection, and parity/framing error reporting.
- Two instances cross-connected (tx->rx) form a point-to-point link.

Parameters:
- DATA_W, 8: payload bits per frame (1..16).
- CLKS_PER_BIT, 4: clock cycles per serial bit. Even, at least 4.
- FIFO_DEPTH, 4: TX buffer entries. Power of two, at least 2.
- PARITY_EN, 1: 1 inserts and checks an even-parity bit; 0 omits it.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- tr_start  in  1  push `din` into the TX FIFO this cycle.
- din  in  DATA_W  word to transmit.
- tr_free  out  1  TX FIFO not full (push will be accepted).
- tx_busy  out  1  framer is mid-frame or the FIFO is non-empty.
- tx  out  1  serial output, idle high, registered.
- rx  in  1  serial input, asynchronous to the frame.
- rec_complete  out  1  one-cycle pulse: a frame was received.
- dout  out  DATA_W  last received word, held until the next rec_complete.
- parity_err  out  1  valid with rec_complete: parity mismatch (always 0 when PARITY_EN=0).
- frame_err  out  1  valid with rec_complete: stop bit sampled as 0.

Behaviour:
- Reset values: tx=1, tr_free=1, tx_busy=0, rec_complete=0, dout=0, parity_err=0, frame_err=0. Reset also empties the FIFO and sends both FSMs to IDLE, including when a frame is in flight; `tx` returns high on the next edge.
- Frame format: start bit 0; data LSB first; parity = XOR of the data bits (if PARITY_EN); stop bit 1. Each bit lasts exactly CLKS_PER_BIT cycles.
- FIFO:
  - A push is accepted iff tr_start=1 and the FIFO is not full at the edge. A push while full is dropped silently.
  - Push and pop in the same cycle are both honoured.
  - Read/write pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
  - tr_free = !full, computed combinationally from the registered count.
- TX FSM: IDLE -> START -> DATA -> (PARITY) -> STOP.
  - IDLE with FIFO non-empty: pop the head into the shift register and enter START. `tx` goes low on the next edge.
  - Latency: tr_start sampled at edge n into an empty FIFO and idle framer gives tx=0 from edge n+2.
  - At the last STOP cycle, if the FIFO is non-empty, go directly to START (no extra idle bit). Otherwise go to IDLE.
  - A bit counter counts DATA_W data bits. A divider counts 0..CLKS_PER_BIT-1.
- RX:
  - `rx` passes through a 2-flop synchroniser.
  - RX FSM: IDLE -> START_CHK -> DATA -> (PARITY) -> STOP.
  - IDLE: a synchronised falling edge enters START_CHK.
  - START_CHK: sample at CLKS_PER_BIT/2 cycles. If the line is 1, the start was a glitch: return to IDLE with no pulse. If 0, continue.
  - Each later bit is sampled every CLKS_PER_BIT cycles from that midpoint.
  - After the stop sample: on the next edge rec_complete=1 for one cycle, dout is loaded, and parity_err/frame_err are set for that cycle (otherwise 0). The FSM returns to IDLE and can detect a new start immediately.
  - A frame with frame_err still updates dout and pulses rec_complete.
- TX and RX are independent; simultaneous activity in both directions is required to work.

Decomposition:
- Package hub_port_pkg holds:
  - TX and RX state encodings;
  - helper function clog2;
  - constant FRAME_BITS = 1 + DATA_W + PARITY_EN + 1.
- Sub-module hub_port_fifo: synchronous FIFO parametrised by width and depth; push/pop/full/empty/count.
- Framer and deframer stay inline in hub_port_gen.

Test Plan (DATA_W=8, CLKS_PER_BIT=4, PARITY_EN=1 unless noted):
- Two cross-connected instances. A sends 0x47, then B sends 0x81 overlapping A's frame. Required: B gets rec_complete with dout=0x47, A gets dout=0x81, no error flags, each frame 44 cycles on the wire.
- Five back-to-back pushes 0x01..0x05 into an idle port (FIFO_DEPTH=4):
  - tr_free falls after the fifth push.
  - 0x05 is accepted only because the first pop occurred; a sixth push while full is dropped.
  - The receiver sees 0x01..0x05 contiguously, with no idle bits between frames.
- Bench drives `rx` with 0x47 framed with odd parity: rec_complete with dout=0x47, parity_err=1, frame_err=0. Repeat with stop=0: frame_err=1.
- A 1-cycle low glitch on idle `rx`: no rec_complete, and a valid frame 0xA5 immediately after is received correctly.
- Reset asserted for one cycle mid-DATA of a transmit with 2 words queued: tx=1 after the next edge, tr_free=1, tx_busy=0, and no further frames are emitted.
- PARITY_EN=0, DATA_W=12: send 0xABC. Required: 56-cycle frame, dout=0xABC, parity_err=0.
